// File: rtl/sprite_blitter.sv
// Sprite-ROM to frame-buffer copier, one pixel per clock, with off-screen clipping.
// Define BLIT_TRANSPARENT_EN to skip pixels whose palette index equals TRANSPARENT_IDX.
module sprite_blitter #(
  parameter int unsigned DATA_W          = 4,
  parameter int unsigned SCREEN_W        = 640,
  parameter int unsigned SCREEN_H        = 480,
  parameter int unsigned TRANSPARENT_IDX = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [18:0]       spr_base,
  input  logic [9:0]        spr_w,
  input  logic [8:0]        spr_h,
  input  logic [9:0]        dst_x,
  input  logic [8:0]        dst_y,
  output logic [18:0]       rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              fb_we,
  output logic [18:0]       fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned XW     = 10;
  localparam int unsigned YW     = 9;
  localparam int unsigned PW     = 11;
  localparam int unsigned LIN_W  = 22;

`ifdef BLIT_TRANSPARENT_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t state, next_state;

  logic [XW-1:0] w_q, x_q, col, col1;
  logic [YW-1:0] h_q, y_q, row, row1;
  logic          vld0, vld1;

  logic          accept_c, size_ok_c, last_col_c, last_row_c, last_px_c;
  logic [PW-1:0] px_c, py_c;
  logic          clip_c, transp_c;

  assign accept_c   = (state == S_IDLE) && start;
  assign size_ok_c  = (spr_w != '0) && (spr_h != '0);
  assign last_col_c = (col == w_q - XW'(1));
  assign last_row_c = (row == h_q - YW'(1));
  assign last_px_c  = last_col_c && last_row_c;

  // Screen coordinates of the pixel whose ROM data is arriving this cycle
  assign px_c     = PW'(x_q) + PW'(col1);
  assign py_c     = PW'(y_q) + PW'(row1);
  assign clip_c   = (px_c >= PW'(SCREEN_W)) || (py_c >= PW'(SCREEN_H));
  assign transp_c = TRANSP_EN && (rom_data == DATA_W'(TRANSPARENT_IDX));

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = size_ok_c ? S_READ : S_DRAIN;
      S_READ:  if (last_px_c) next_state = S_DRAIN;
      // Leave once both pipeline stages are empty, i.e. the last write is out
      S_DRAIN: if (!vld0 && !vld1) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Address issue, tag pipeline and frame-buffer write stage
  always_ff @(posedge Clk) begin
    if (Reset) begin
      w_q      <= '0;
      h_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      col      <= '0;
      row      <= '0;
      col1     <= '0;
      row1     <= '0;
      vld0     <= 1'b0;
      vld1     <= 1'b0;
      rom_addr <= '0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy  <= (next_state != S_IDLE);
      done  <= (next_state == S_DONE);
      vld1  <= vld0;
      col1  <= col;
      row1  <= row;
      fb_we <= vld1 && !clip_c && !transp_c;
      if (vld1) begin
        fb_addr <= ADDR_W'(LIN_W'(py_c) * LIN_W'(SCREEN_W) + LIN_W'(px_c));
        fb_data <= rom_data;
      end
      if (accept_c) begin
        w_q      <= spr_w;
        h_q      <= spr_h;
        x_q      <= dst_x;
        y_q      <= dst_y;
        col      <= '0;
        row      <= '0;
        rom_addr <= spr_base;
        vld0     <= size_ok_c;
      end else if (state == S_READ) begin
        if (last_px_c) begin
          vld0 <= 1'b0;
        end else begin
          rom_addr <= rom_addr + ADDR_W'(1);
          if (last_col_c) begin
            col <= '0;
            row <= row + YW'(1);
          end else begin
            col <= col + XW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed self-checking bench for sprite_blitter with a synchronous sprite ROM model.
module tb_sprite_blitter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [18:0] spr_base;
  logic [9:0]  spr_w;
  logic [8:0]  spr_h;
  logic [9:0]  dst_x;
  logic [8:0]  dst_y;
  logic [18:0] rom_addr;
  logic [3:0]  rom_data;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [3:0]  fb_data;
  logic        busy;
  logic        done;

  int vecs = 0;
  int errs = 0;

  logic [3:0] rom [0:255];

  sprite_blitter #(
    .DATA_W(4), .SCREEN_W(640), .SCREEN_H(480), .TRANSPARENT_IDX(0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .spr_base(spr_base),
    .spr_w(spr_w), .spr_h(spr_h), .dst_x(dst_x), .dst_y(dst_y),
    .rom_addr(rom_addr), .rom_data(rom_data), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) rom_data <= rom[rom_addr[7:0]];

  // Drives a start pulse; returns 1ns after the accepting edge E0
  task automatic start_blit(input logic [18:0] b, input logic [9:0] w, input logic [8:0] h,
                            input logic [9:0] x, input logic [8:0] y);
    spr_base = b; spr_w = w; spr_h = h; dst_x = x; dst_y = y;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = 1'b0;
    spr_base = '0; spr_w = '0; spr_h = '0; dst_x = '0; dst_y = '0;
    repeat (2) @(posedge Clk);
    #1;
    vecs++;
    if (fb_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errs++; $display("FAIL reset_ctrl: fb_we=%b busy=%b done=%b required 0 0 0", fb_we, busy, done);
    end
    vecs++;
    if (rom_addr !== 19'd0 || fb_addr !== 19'd0 || fb_data !== 4'd0) begin
      errs++; $display("FAIL reset_data: rom_addr=%0d fb_addr=%0d fb_data=%0d required 0 0 0",
                       rom_addr, fb_addr, fb_data);
    end
    Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_basic();
    logic [18:0] ea [4];
    logic [3:0]  ed [4];
    logic        exp_done, exp_busy;
    ea[0] = 19'd3210; ea[1] = 19'd3211; ea[2] = 19'd3850; ea[3] = 19'd3851;
    ed[0] = 4'd1; ed[1] = 4'd2; ed[2] = 4'd3; ed[3] = 4'd4;
    for (int i = 0; i < 4; i++) rom[i] = ed[i];
    start_blit(19'd0, 10'd2, 9'd2, 10'd10, 9'd5);
    vecs++;
    if (busy !== 1'b1 || rom_addr !== 19'd0) begin
      errs++; $display("FAIL basic_e0: busy=%b rom_addr=%0d required 1 0", busy, rom_addr);
    end
    for (int c = 1; c <= 7; c++) begin
      @(posedge Clk); #1;
      exp_done = (c == 6);
      exp_busy = (c <= 6);
      if (c <= 3) begin
        vecs++;
        if (rom_addr !== 19'(c)) begin
          errs++; $display("FAIL basic_rom_addr c=%0d: got %0d required %0d", c, rom_addr, c);
        end
      end
      vecs++;
      if (c >= 2 && c <= 5) begin
        if (fb_we !== 1'b1 || fb_addr !== ea[c-2] || fb_data !== ed[c-2]) begin
          errs++; $display("FAIL basic_write c=%0d: we=%b addr=%0d data=%0d required 1 %0d %0d",
                           c, fb_we, fb_addr, fb_data, ea[c-2], ed[c-2]);
        end
      end else if (fb_we !== 1'b0) begin
        errs++; $display("FAIL basic_idle_we c=%0d: got %b required 0", c, fb_we);
      end
      vecs++;
      if (done !== exp_done || busy !== exp_busy) begin
        errs++; $display("FAIL basic_status c=%0d: done=%b busy=%b required %b %b",
                         c, done, busy, exp_done, exp_busy);
      end
    end
  endtask

  task automatic test_clip();
    logic exp_done;
    rom[100] = 4'd5; rom[101] = 4'd6; rom[102] = 4'd7; rom[103] = 4'd8;
    start_blit(19'd100, 10'd4, 9'd1, 10'd638, 9'd0);
    for (int c = 1; c <= 7; c++) begin
      @(posedge Clk); #1;
      exp_done = (c == 6);
      vecs++;
      if (c == 2 || c == 3) begin
        if (fb_we !== 1'b1 || fb_addr !== 19'(636 + c) || fb_data !== 4'(3 + c)) begin
          errs++; $display("FAIL clip_right_write c=%0d: we=%b addr=%0d data=%0d required 1 %0d %0d",
                           c, fb_we, fb_addr, fb_data, 636 + c, 3 + c);
        end
      end else if (fb_we !== 1'b0) begin
        errs++; $display("FAIL clip_right_we c=%0d: got %b required 0", c, fb_we);
      end
      vecs++;
      if (done !== exp_done) begin
        errs++; $display("FAIL clip_right_done c=%0d: got %b required %b", c, done, exp_done);
      end
    end
    rom[104] = 4'd9; rom[105] = 4'd10;
    start_blit(19'd104, 10'd1, 9'd2, 10'd0, 9'd479);
    for (int c = 1; c <= 5; c++) begin
      @(posedge Clk); #1;
      exp_done = (c == 4);
      vecs++;
      if (c == 2) begin
        if (fb_we !== 1'b1 || fb_addr !== 19'd306560 || fb_data !== 4'd9) begin
          errs++; $display("FAIL clip_bottom_write: we=%b addr=%0d data=%0d required 1 306560 9",
                           fb_we, fb_addr, fb_data);
        end
      end else if (fb_we !== 1'b0) begin
        errs++; $display("FAIL clip_bottom_we c=%0d: got %b required 0", c, fb_we);
      end
      vecs++;
      if (done !== exp_done) begin
        errs++; $display("FAIL clip_bottom_done c=%0d: got %b required %b", c, done, exp_done);
      end
    end
  endtask

  task automatic test_transparent();
    logic exp_we0;
`ifdef BLIT_TRANSPARENT_EN
    exp_we0 = 1'b0;
`else
    exp_we0 = 1'b1;
`endif
    rom[110] = 4'd0; rom[111] = 4'd7;
    start_blit(19'd110, 10'd2, 9'd1, 10'd0, 9'd0);
    for (int c = 1; c <= 5; c++) begin
      @(posedge Clk); #1;
      vecs++;
      if (c == 2) begin
        if (fb_we !== exp_we0 || (exp_we0 && (fb_addr !== 19'd0 || fb_data !== 4'd0))) begin
          errs++; $display("FAIL transp_px0: we=%b addr=%0d data=%0d required %b 0 0",
                           fb_we, fb_addr, fb_data, exp_we0);
        end
      end else if (c == 3) begin
        if (fb_we !== 1'b1 || fb_addr !== 19'd1 || fb_data !== 4'd7) begin
          errs++; $display("FAIL transp_px1: we=%b addr=%0d data=%0d required 1 1 7",
                           fb_we, fb_addr, fb_data);
        end
      end else if (fb_we !== 1'b0) begin
        errs++; $display("FAIL transp_we c=%0d: got %b required 0", c, fb_we);
      end
      if (c == 4) begin
        vecs++;
        if (done !== 1'b1) begin
          errs++; $display("FAIL transp_done: got %b required 1", done);
        end
      end
    end
  endtask

  task automatic test_zero_size();
    logic exp_done, exp_busy;
    start_blit(19'd0, 10'd0, 9'd3, 10'd0, 9'd0);
    vecs++;
    if (busy !== 1'b1 || done !== 1'b0 || fb_we !== 1'b0) begin
      errs++; $display("FAIL zero_e0: busy=%b done=%b we=%b required 1 0 0", busy, done, fb_we);
    end
    for (int c = 1; c <= 3; c++) begin
      @(posedge Clk); #1;
      exp_done = (c == 1);
      exp_busy = (c == 1);
      vecs++;
      if (done !== exp_done || busy !== exp_busy || fb_we !== 1'b0) begin
        errs++; $display("FAIL zero_c%0d: done=%b busy=%b we=%b required %b %b 0",
                         c, done, busy, fb_we, exp_done, exp_busy);
      end
    end
  endtask

  task automatic test_reset_mid_blit();
    logic stray;
    logic exp_done, exp_busy;
    rom[9] = 4'hA;
    start_blit(19'd0, 10'd8, 9'd8, 10'd5, 9'd5);
    for (int c = 1; c <= 11; c++) begin
      @(posedge Clk); #1;
      if (c >= 2) begin
        vecs++;
        if (fb_we !== 1'b1) begin
          errs++; $display("FAIL midrst_we c=%0d: got %b required 1", c, fb_we);
        end
      end
    end
    vecs++;
    if (fb_addr !== 19'd3846 || fb_data !== 4'hA) begin
      errs++; $display("FAIL midrst_10th: addr=%0d data=%0d required 3846 10", fb_addr, fb_data);
    end
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    vecs++;
    if (fb_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rom_addr !== 19'd0) begin
      errs++; $display("FAIL midrst_after: we=%b busy=%b done=%b rom_addr=%0d required 0 0 0 0",
                       fb_we, busy, done, rom_addr);
    end
    stray = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(posedge Clk); #1;
      if (done !== 1'b0 || fb_we !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    vecs++;
    if (stray !== 1'b0) begin
      errs++; $display("FAIL midrst_quiet: activity seen=%b required 0", stray);
    end
    rom[40] = 4'hB;
    start_blit(19'd40, 10'd1, 9'd1, 10'd100, 9'd100);
    for (int c = 1; c <= 4; c++) begin
      @(posedge Clk); #1;
      exp_done = (c == 3);
      exp_busy = (c <= 3);
      vecs++;
      if (c == 2) begin
        if (fb_we !== 1'b1 || fb_addr !== 19'd64100 || fb_data !== 4'hB) begin
          errs++; $display("FAIL post_rst_write: we=%b addr=%0d data=%0d required 1 64100 11",
                           fb_we, fb_addr, fb_data);
        end
      end else if (fb_we !== 1'b0) begin
        errs++; $display("FAIL post_rst_we c=%0d: got %b required 0", c, fb_we);
      end
      vecs++;
      if (done !== exp_done || busy !== exp_busy) begin
        errs++; $display("FAIL post_rst_status c=%0d: done=%b busy=%b required %b %b",
                         c, done, busy, exp_done, exp_busy);
      end
    end
  endtask

  task automatic test_busy_lockout();
    logic [18:0] ea [4];
    int          ndone;
    ea[0] = 19'd3210; ea[1] = 19'd3211; ea[2] = 19'd3850; ea[3] = 19'd3851;
    for (int i = 0; i < 4; i++) rom[i] = 4'(i + 1);
    ndone = 0;
    start_blit(19'd0, 10'd2, 9'd2, 10'd10, 9'd5);
    for (int c = 1; c <= 10; c++) begin
      @(posedge Clk); #1;
      if (done === 1'b1) ndone++;
      if (c >= 2 && c <= 5) begin
        vecs++;
        if (fb_we !== 1'b1 || fb_addr !== ea[c-2] || fb_data !== 4'(c - 1)) begin
          errs++; $display("FAIL lockout_write c=%0d: we=%b addr=%0d data=%0d required 1 %0d %0d",
                           c, fb_we, fb_addr, fb_data, ea[c-2], c - 1);
        end
      end
      if (c == 2) begin
        spr_base = 19'd50; spr_w = 10'd3; spr_h = 9'd3; dst_x = 10'd300; dst_y = 9'd200;
        start = 1'b1;
      end else if (c == 3) begin
        start = 1'b0;
      end
    end
    vecs++;
    if (ndone !== 1) begin
      errs++; $display("FAIL lockout_done_count: got %0d required 1", ndone);
    end
    vecs++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL lockout_idle: busy=%b required 0", busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 4'((i % 15) + 1);
    test_reset();
    test_basic();
    test_clip();
    test_transparent();
    test_zero_size();
    test_reset_mid_blit();
    test_busy_lockout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
